// File: rtl/sm4_stream_ctrl_if.sv
// sm4_stream_ctrl_if
//   Link between the stream controller (master) and the sm4_encryptor (slave).
//   Forward channel: one 128-bit group plus key, mask word and mode, issued
//   with v/ready. Return channel: the 128-bit result, offered with crypt_v and
//   accepted with yumi.
//   Signals:
//     content      128  group to cipher
//     key          128  cipher key
//     random       32   random mask word
//     decode       1    1 = decrypt
//     protection_v 1    enable the encryptor's encrypt/decrypt self-check
//     v / ready    1    group issue handshake
//     crypt        128  cipher result
//     crypt_v/yumi 1    result handshake (yumi only while crypt_v)
interface sm4_stream_ctrl_if;
  logic [127:0] content;
  logic [127:0] key;
  logic [31:0]  random;
  logic         decode;
  logic         protection_v;
  logic         v;
  logic         ready;
  logic [127:0] crypt;
  logic         crypt_v;
  logic         yumi;

  modport master (
    output content, key, random, decode, protection_v, v, yumi,
    input  ready, crypt, crypt_v
  );

  modport slave (
    input  content, key, random, decode, protection_v, v, yumi,
    output ready, crypt, crypt_v
  );
endinterface

// File: rtl/sm4_stream_ctrl.sv
// sm4_stream_ctrl
//   Initiator for sm4_encryptor. Packs a 32-bit word stream into 128-bit
//   groups, issues each group to the encryptor, collects the result and
//   re-serialises it as 32-bit words (most significant word first).
//   Supports ECB and CBC chaining and supplies the mask word from an LFSR.
//   Ports:
//     clk_i, reset_i        clock, synchronous active-high reset
//     start_i               latch key/iv/cbc/decode, begin message (idle only)
//     key_i, iv_i           cipher key, CBC initial vector
//     cbc_i, decode_i       chaining mode, direction
//     data_i, last_i        input word; last_i sampled with 4th word of group
//     v_i / ready_o         input word handshake
//     data_o, last_o        output word; last_o with 4th word of last group
//     v_o / yumi_i          output word handshake
//     busy_o                message in progress
//     enc                   encryptor link (master side)
module sm4_stream_ctrl #(
  parameter logic [31:0] lfsr_seed_p  = 32'hACE1_2468,
  parameter bit          protection_p = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [127:0]              key_i,
  input  logic [127:0]              iv_i,
  input  logic                      cbc_i,
  input  logic                      decode_i,
  input  logic [31:0]               data_i,
  input  logic                      last_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [31:0]               data_o,
  output logic                      last_o,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic                      busy_o,
  sm4_stream_ctrl_if.master         enc
);

  // A zero LFSR state would lock up, so a zero seed is replaced.
  localparam logic [31:0] SeedLp = (lfsr_seed_p == 32'h0) ? 32'h1 : lfsr_seed_p;
  localparam logic [31:0] TapsLp = 32'h8020_0003;

  typedef enum logic [2:0] {eIdle, eFill, eIssue, eWait, eDrain} state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  lfsr_q, lfsr_d;
  logic [127:0] in_q, out_q, chain_q, key_q;
  logic         cbc_q, decode_q, last_q;
  logic [127:0] content_w, result_w;

  // ---------------- state register ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= eIdle;
    else         state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      eIdle:  if (start_i) state_d = eFill;
      eFill:  if (v_i && cnt_q == 2'd3) state_d = eIssue;
      eIssue: if (enc.ready) state_d = eWait;
      eWait:  if (enc.crypt_v) state_d = eDrain;
      eDrain: if (yumi_i && cnt_q == 2'd3) state_d = last_q ? eIdle : eFill;
      default: state_d = eIdle;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    ready_o  = 1'b0;
    v_o      = 1'b0;
    enc.v    = 1'b0;
    enc.yumi = 1'b0;
    busy_o   = (state_q != eIdle);
    unique case (state_q)
      eFill:  ready_o  = 1'b1;
      eIssue: enc.v    = 1'b1;
      eWait:  enc.yumi = enc.crypt_v;   // result is always accepted on arrival
      eDrain: v_o      = 1'b1;
      default: ;
    endcase
  end

  assign last_o = (state_q == eDrain) && last_q && (cnt_q == 2'd3);
  assign data_o = out_q[127:96];

  // ---------------- word counter and LFSR ----------------
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == eFill && v_i) || (state_q == eDrain && yumi_i))
      cnt_d = cnt_q + 2'd1;                 // wraps 3->0 at group boundary
    else if (state_q == eIdle && start_i)
      cnt_d = 2'd0;
  end

  // Galois form, right-shifting: feedback from bit 0 into the tap positions.
  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TapsLp) : (lfsr_q >> 1);

  // ---------------- chaining datapath ----------------
  // CBC encrypt whitens the plaintext with the previous ciphertext before
  // issue; CBC decrypt whitens the result after capture instead.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign content_w[gi*32 +: 32] = in_q[gi*32 +: 32] ^
        ((cbc_q && !decode_q) ? chain_q[gi*32 +: 32] : 32'h0);
      assign result_w[gi*32 +: 32] = enc.crypt[gi*32 +: 32] ^
        ((cbc_q && decode_q) ? chain_q[gi*32 +: 32] : 32'h0);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= 2'd0;
      lfsr_q   <= SeedLp;
      in_q     <= '0;
      out_q    <= '0;
      chain_q  <= '0;
      key_q    <= '0;
      cbc_q    <= 1'b0;
      decode_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      unique case (state_q)
        eIdle: if (start_i) begin
          key_q    <= key_i;
          cbc_q    <= cbc_i;
          decode_q <= decode_i;
          chain_q  <= iv_i;
        end
        eFill: if (v_i) begin
          // after four shifts the first word sits in [127:96]
          in_q <= {in_q[95:0], data_i};
          if (cnt_q == 2'd3) last_q <= last_i;
        end
        eWait: if (enc.crypt_v) begin
          out_q <= result_w;
          if (cbc_q) chain_q <= decode_q ? in_q : enc.crypt;
        end
        eDrain: if (yumi_i) out_q <= {out_q[95:0], 32'h0};
        default: ;
      endcase
    end
  end

  assign enc.content      = content_w;
  assign enc.key          = key_q;
  assign enc.random       = lfsr_q;
  assign enc.decode       = decode_q;
  assign enc.protection_v = protection_p;

endmodule

// File: tb/tb_sm4_stream_ctrl.sv
// tb_sm4_stream_ctrl
//   Directed bench for sm4_stream_ctrl. A behavioural encryptor stand-in
//   answers the standard SM4 vector (and its inverse) exactly; any other
//   group gets a distinct substitute value so mis-chained content shows up
//   in the output words.
module tb_sm4_stream_ctrl;

  localparam logic [127:0] K  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C  = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [127:0] iv_i = '0;
  logic         cbc_i = 1'b0;
  logic         decode_i = 1'b0;
  logic [31:0]  data_i = '0;
  logic         last_i = 1'b0;
  logic         v_i = 1'b0;
  logic         ready_o;
  logic [31:0]  data_o;
  logic         last_o;
  logic         v_o;
  logic         yumi_i = 1'b0;
  logic         busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int enc_lat   = 2;
  int enc_stall = 0;

  sm4_stream_ctrl_if enc_if ();

  sm4_stream_ctrl dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .key_i    (key_i),
    .iv_i     (iv_i),
    .cbc_i    (cbc_i),
    .decode_i (decode_i),
    .data_i   (data_i),
    .last_i   (last_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .last_o   (last_o),
    .v_o      (v_o),
    .yumi_i   (yumi_i),
    .busy_o   (busy_o),
    .enc      (enc_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fake_cipher(input logic [127:0] x, input logic d,
                                               input logic [127:0] k);
    if (!d && x == P && k == K) return C;
    if (d && x == C && k == K) return P;
    return x ^ k ^ 128'h5a5a_5a5a_a5a5_a5a5_3c3c_3c3c_c3c3_c3c3;
  endfunction

  // Encryptor stand-in: drives on the falling edge, samples 1 time unit later.
  initial begin
    logic         pend_issue, pend_ret, prev_v, cap_d;
    logic [127:0] cap_c, cap_k, res, prev_c;
    int           lat;
    pend_issue = 0; pend_ret = 0; prev_v = 0; cap_d = 0;
    cap_c = '0; cap_k = '0; res = '0; prev_c = '0; lat = 0;
    enc_if.ready = 1'b1; enc_if.crypt = '0; enc_if.crypt_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        lat = 0; pend_issue = 0; pend_ret = 0; prev_v = 0;
        enc_if.crypt_v = 1'b0; enc_if.ready = 1'b1;
      end else begin
        if (pend_ret) enc_if.crypt_v = 1'b0;
        if (pend_issue) begin
          res = fake_cipher(cap_c, cap_d, cap_k);
          lat = enc_lat;
        end
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            enc_if.crypt = res;
            enc_if.crypt_v = 1'b1;
          end
        end
        enc_if.ready = (enc_stall == 0);
        #1;
        if (enc_if.v && prev_v) check("issue_hold", enc_if.content, prev_c);
        prev_v = enc_if.v;
        prev_c = enc_if.content;
        pend_issue = enc_if.v & enc_if.ready;
        if (pend_issue) begin
          cap_c = enc_if.content; cap_d = enc_if.decode; cap_k = enc_if.key;
        end
        pend_ret = enc_if.crypt_v & enc_if.yumi;
        if (enc_if.v && enc_stall > 0) enc_stall--;
      end
    end
  end

  task automatic start_msg(input logic [127:0] k, input logic [127:0] iv,
                           input logic cbc, input logic dec);
    @(negedge clk);
    start_i = 1; key_i = k; iv_i = iv; cbc_i = cbc; decode_i = dec;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic push(input logic [31:0] w, input logic l);
    int t;
    @(negedge clk);
    v_i = 1; data_i = w; last_i = l; t = 0;
    #1;
    while (!ready_o && t < 100) begin @(negedge clk); #1; t++; end
    if (!ready_o) check("push_timeout", ready_o, 1);
  endtask

  task automatic send_group(input logic [127:0] blk, input logic l);
    for (int i = 0; i < 4; i++) push(blk[127 - 32*i -: 32], (i == 3) ? l : 1'b0);
    @(negedge clk);
    v_i = 0; last_i = 0;
  endtask

  // stall_idx: word index before whose acceptance yumi_i is held low 5 cycles.
  task automatic recv_group(input string tag, input logic [127:0] exp,
                            input logic exp_last, input int stall_idx);
    int t;
    logic [31:0] held;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      yumi_i = 0; t = 0;
      #1;
      while (!v_o && t < 100) begin @(negedge clk); #1; t++; end
      check({tag, "_v"}, v_o, 1);
      if (i == stall_idx) begin
        held = data_o;
        repeat (5) begin
          @(negedge clk); #1;
          check({tag, "_hold_data"}, data_o, held);
          check({tag, "_hold_v"}, v_o, 1);
        end
      end
      check({tag, "_data"}, data_o, exp[127 - 32*i -: 32]);
      check({tag, "_last"}, last_o, (exp_last && i == 3));
      yumi_i = 1;
    end
    @(negedge clk);
    yumi_i = 0;
    $display("[TB] %s: group expected %h last=%0b", tag, exp, exp_last);
  endtask

  initial begin
    int t;
    // ---- reset state and LFSR sequence ----
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 0);
    check("rst_v", v_o, 0);
    check("rst_last", last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_enc_v", enc_if.v, 0);
    check("rst_enc_yumi", enc_if.yumi, 0);
    check("rst_data", data_o, 0);
    check("rst_lfsr", enc_if.random, 32'hACE1_2468);
    check("protection", enc_if.protection_v, 1);
    reset_i = 0;
    @(negedge clk);
    check("lfsr_1", enc_if.random, 32'h5670_9234);
    @(negedge clk);
    check("lfsr_2", enc_if.random, 32'h2B38_491A);
    @(negedge clk);
    check("lfsr_3", enc_if.random, 32'h159C_248D);
    @(negedge clk);
    check("lfsr_4", enc_if.random, 32'h8AEE_1245);

    // ---- ECB encrypt ----
    start_msg(K, '0, 0, 0);
    check("fill_ready", ready_o, 1);
    send_group(P, 1);
    recv_group("ecb_enc", C, 1, -1);
    check("ecb_enc_idle", busy_o, 0);

    // ---- ECB decrypt ----
    start_msg(K, '0, 0, 1);
    send_group(C, 1);
    recv_group("ecb_dec", P, 1, -1);

    // ---- CBC encrypt, IV = 0, two groups ----
    start_msg(K, '0, 1, 0);
    send_group(P, 0);
    recv_group("cbc_enc1", C, 0, -1);
    check("cbc_enc_mid_busy", busy_o, 1);
    send_group(C ^ P, 1);
    recv_group("cbc_enc2", C, 1, -1);

    // ---- CBC decrypt, IV = 0, two groups ----
    start_msg(K, '0, 1, 1);
    send_group(C, 0);
    recv_group("cbc_dec1", P, 0, -1);
    send_group(C, 1);
    recv_group("cbc_dec2", P ^ C, 1, -1);

    // ---- backpressure on both sides ----
    enc_stall = 3;
    start_msg(K, '0, 0, 0);
    send_group(P, 1);
    recv_group("bp", C, 1, 2);
    check("bp_stall_used", enc_stall, 0);

    // ---- reset while waiting for the result ----
    enc_lat = 6;
    start_msg(K, '0, 0, 0);
    send_group(P, 1);
    t = 0;
    #2;
    while (!(enc_if.v && enc_if.ready) && t < 50) begin @(negedge clk); #2; t++; end
    check("abort_issue_seen", enc_if.v & enc_if.ready, 1);
    @(negedge clk);
    check("abort_in_wait", busy_o & ~enc_if.v, 1);
    reset_i = 1;
    @(negedge clk);
    check("abort_ready", ready_o, 0);
    check("abort_v", v_o, 0);
    check("abort_last", last_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_enc_v", enc_if.v, 0);
    check("abort_enc_yumi", enc_if.yumi, 0);
    check("abort_data", data_o, 0);
    check("abort_content", enc_if.content, 0);
    check("abort_key", enc_if.key, 0);
    check("abort_lfsr", enc_if.random, 32'hACE1_2468);
    @(negedge clk);
    reset_i = 0;
    enc_lat = 2;
    start_msg(K, '0, 0, 0);
    send_group(P, 1);
    recv_group("after_abort", C, 1, -1);

    // ---- start_i during fill and early last_i are ignored ----
    start_msg(K, '0, 0, 0);
    push(P[127:96], 0);
    start_i = 1; key_i = '0; iv_i = '1; cbc_i = 1; decode_i = 1;
    push(P[95:64], 1);
    start_i = 0;
    push(P[63:32], 0);
    push(P[31:0], 0);
    @(negedge clk);
    v_i = 0; last_i = 0;
    recv_group("ign1", C, 0, -1);
    #1;
    check("ign_still_busy", busy_o, 1);
    check("ign_back_to_fill", ready_o, 1);
    send_group(P, 1);
    recv_group("ign2", C, 1, -1);
    check("ign_idle", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
